// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter
//   Round-robin arbiter that lets two AXI-Lite masters share one AXI-Lite
//   SRAM controller. One complete transaction is granted at a time: a write
//   (AW + W, then B) or a read (AR, then R). Channels are routed
//   combinationally between the granted master and the downstream port.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   m_aw*/m_w*/m_b*     per-master write channels, master i in slice i
//   m_ar*/m_r*          per-master read channels, master i in slice i
//   s_aw*/s_w*/s_b*     downstream write channels to the SRAM controller
//   s_ar*/s_r*          downstream read channels to the SRAM controller
//   grant               one-hot owner of the downstream port, 0 when idle
//   txn_cnt0/txn_cnt1   completed transactions per master (saturating),
//                       present only when SRAM_AXI_ARBITER_STATS_EN is defined
module sram_axi_arbiter #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*ADDR_BITS-1:0] m_awaddr,
  input  logic [1:0]             m_awvalid,
  output logic [1:0]             m_awready,
  input  logic [2*DATA_BITS-1:0] m_wdata,
  input  logic [1:0]             m_wvalid,
  output logic [1:0]             m_wready,
  output logic [3:0]             m_bresp,
  output logic [1:0]             m_bvalid,
  input  logic [1:0]             m_bready,
  input  logic [2*ADDR_BITS-1:0] m_araddr,
  input  logic [1:0]             m_arvalid,
  output logic [1:0]             m_arready,
  output logic [2*DATA_BITS-1:0] m_rdata,
  output logic [3:0]             m_rresp,
  output logic [1:0]             m_rvalid,
  input  logic [1:0]             m_rready,
  output logic [ADDR_BITS-1:0]   s_awaddr,
  output logic                   s_awvalid,
  input  logic                   s_awready,
  output logic [DATA_BITS-1:0]   s_wdata,
  output logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic [1:0]             s_bresp,
  input  logic                   s_bvalid,
  output logic                   s_bready,
  output logic [ADDR_BITS-1:0]   s_araddr,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic [DATA_BITS-1:0]   s_rdata,
  input  logic [1:0]             s_rresp,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  output logic [1:0]             grant
`ifdef SRAM_AXI_ARBITER_STATS_EN
  ,
  output logic [15:0]            txn_cnt0,
  output logic [15:0]            txn_cnt1
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t     r_state, w_state_next;
  logic [1:0] r_grant, w_grant_next;
  logic       r_last, w_last_next;
  logic       r_aw_done, w_aw_done_next;
  logic       r_w_done, w_w_done_next;

  logic [1:0] w_wreq, w_req;
  logic       w_pick, w_sel;
  logic       w_in_wa, w_in_wb, w_in_ra, w_in_rd;
  logic       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_wreq = m_awvalid & m_wvalid;
  assign w_req  = w_wreq | m_arvalid;
  // On a tie the master not served last wins; otherwise the lone requester.
  assign w_pick = (&w_req) ? ~r_last : ~w_req[0];
  assign w_sel  = r_grant[1];

  assign w_in_wa = (r_state == WR_ADDR_DATA);
  assign w_in_wb = (r_state == WR_RESP);
  assign w_in_ra = (r_state == RD_ADDR);
  assign w_in_rd = (r_state == RD_DATA);

  // Downstream side: granted master's channels, valids gated by state.
  assign s_awaddr  = w_sel ? m_awaddr[2*ADDR_BITS-1:ADDR_BITS] : m_awaddr[ADDR_BITS-1:0];
  assign s_araddr  = w_sel ? m_araddr[2*ADDR_BITS-1:ADDR_BITS] : m_araddr[ADDR_BITS-1:0];
  assign s_wdata   = w_sel ? m_wdata[2*DATA_BITS-1:DATA_BITS] : m_wdata[DATA_BITS-1:0];
  // A channel that already handshook is masked so it is never sent twice.
  assign s_awvalid = w_in_wa & m_awvalid[w_sel] & ~r_aw_done;
  assign s_wvalid  = w_in_wa & m_wvalid[w_sel] & ~r_w_done;
  assign s_bready  = w_in_wb & m_bready[w_sel];
  assign s_arvalid = w_in_ra & m_arvalid[w_sel];
  assign s_rready  = w_in_rd & m_rready[w_sel];

  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid & s_wready;
  assign w_b_hs  = s_bvalid & s_bready;
  assign w_ar_hs = s_arvalid & s_arready;
  assign w_r_hs  = s_rvalid & s_rready;

  // Master side: only the granted master ever sees ready/valid.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign m_awready[gi] = w_in_wa & r_grant[gi] & ~r_aw_done & s_awready;
      assign m_wready[gi]  = w_in_wa & r_grant[gi] & ~r_w_done & s_wready;
      assign m_bvalid[gi]  = w_in_wb & r_grant[gi] & s_bvalid;
      assign m_bresp[2*gi +: 2] = (w_in_wb & r_grant[gi]) ? s_bresp : 2'b00;
      assign m_arready[gi] = w_in_ra & r_grant[gi] & s_arready;
      assign m_rvalid[gi]  = w_in_rd & r_grant[gi] & s_rvalid;
      assign m_rresp[2*gi +: 2] = (w_in_rd & r_grant[gi]) ? s_rresp : 2'b00;
      assign m_rdata[gi*DATA_BITS +: DATA_BITS] =
        (w_in_rd & r_grant[gi]) ? s_rdata : {DATA_BITS{1'b0}};
    end
  endgenerate

  assign grant = r_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_last    <= w_last_next;
      r_aw_done <= w_aw_done_next;
      r_w_done  <= w_w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant;
    w_last_next    = r_last;
    w_aw_done_next = r_aw_done;
    w_w_done_next  = r_w_done;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_next   = w_pick ? 2'b10 : 2'b01;
          w_last_next    = w_pick;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
          // Within one master a pending write goes before a pending read.
          w_state_next   = w_wreq[w_pick] ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        w_aw_done_next = r_aw_done | w_aw_hs;
        w_w_done_next  = r_w_done | w_w_hs;
        if (w_aw_done_next && w_w_done_next) begin
          w_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_state_next   = IDLE;
          w_grant_next   = 2'b00;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          w_state_next = IDLE;
          w_grant_next = 2'b00;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 2'b00;
      end
    endcase
  end

`ifdef SRAM_AXI_ARBITER_STATS_EN
  logic [1:0][15:0] r_txn_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txn_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((w_b_hs | w_r_hs) && r_grant[i] && (r_txn_cnt[i] != 16'hFFFF)) begin
          r_txn_cnt[i] <= r_txn_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign txn_cnt0 = r_txn_cnt[0];
  assign txn_cnt1 = r_txn_cnt[1];
`endif

endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
Two-requester round-robin arbiter that shares one AXI-Lite SRAM controller (AW/W/B, AR/R channels) between two AXI-Lite masters, e.g. a pattern tester and a display/DMA reader. It grants one complete transaction at a time: a write (AW+W then B) or a read (AR then R). Channels are routed combinationally to and from the granted master. It sits between the masters and the SRAM controller that drives the sram_io pins.

Parameters:
ADDR_BITS, 20, address width per master and downstream.
DATA_BITS, 16, data width per master and downstream.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
m_awaddr  input  2*ADDR_BITS  master write addresses; master i at slice [i*ADDR_BITS +: ADDR_BITS]
m_awvalid  input  2  per-master AW valid
m_awready  output  2  per-master AW ready
m_wdata  input  2*DATA_BITS  per-master write data
m_wvalid  input  2  per-master W valid
m_wready  output  2  per-master W ready
m_bresp  output  4  per-master B response, 2 bits each
m_bvalid  output  2  per-master B valid
m_bready  input  2  per-master B ready
m_araddr  input  2*ADDR_BITS  per-master read address
m_arvalid  input  2  per-master AR valid
m_arready  output  2  per-master AR ready
m_rdata  output  2*DATA_BITS  per-master read data
m_rresp  output  4  per-master R response
m_rvalid  output  2  per-master R valid
m_rready  input  2  per-master R ready
s_awaddr/s_awvalid/s_awready, s_wdata/s_wvalid/s_wready, s_bresp/s_bvalid/s_bready, s_araddr/s_arvalid/s_arready, s_rdata/s_rresp/s_rvalid/s_rready  mirror directions  ADDR_BITS/DATA_BITS/2/1  single downstream port to the SRAM controller
grant  output  2  one-hot current grant; 0 when IDLE

Behaviour:
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA. Registered: state, grant, last (master last granted), aw_done, w_done.
- Reset: state=IDLE, grant=0, last=1 so master 0 wins the first tie. All m_*ready, m_*valid, s_*valid and s_*ready outputs are 0.
- Request per master i: wreq_i = m_awvalid[i] & m_wvalid[i]; rreq_i = m_arvalid[i]; req_i = wreq_i | rreq_i.
- IDLE:
  - If both req: pick master !last. Otherwise pick the single requester.
  - Within a master, write has priority over read.
  - Register grant, set last=picked. Go to WR_ADDR_DATA or RD_ADDR.
  - Grant takes effect the next cycle: 1-cycle arbitration latency. No downstream valid is driven in IDLE.
- WR_ADDR_DATA:
  - Forward AW and W of the granted master to s_*. Routed readys go to the granted master only.
  - AW and W may complete in either order or the same cycle. aw_done/w_done mask the finished channel's valid.
  - When both are done, go to WR_RESP.
- WR_RESP: route s_b* to the granted master's b*, and its bready to s_bready. On handshake (s_bvalid & s_bready) go to IDLE, grant=0, clear aw_done/w_done.
- RD_ADDR: forward AR. On handshake go to RD_DATA.
- RD_DATA: route s_r* to the granted master's r* and its rready to s_rready. On handshake go to IDLE.
- Non-granted master: all its readys and valids are held 0. Its requests stay pending; there is no drop or timeout.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1.
- Minimum cost: one IDLE cycle between transactions, so back-to-back throughput is one transaction per (downstream latency + 1) cycles.
- Reset mid-transaction: immediate return to reset values. An in-flight downstream transaction is abandoned; the SRAM controller is reset together with the arbiter.
- Master deasserting valid before handshake is an AXI violation. Behaviour is undefined, with no lockup requirement beyond reset.

Optional Feature:
- Macro SRAM_AXI_ARBITER_STATS_EN. When defined, adds output ports txn_cnt0 and txn_cnt1, 16 bits each.
- Each counter increments on completion of a B or R handshake for that master. It saturates at 0xFFFF and resets to 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Single write: master 0 writes addr 0x3, data 0x2 (ADDR_BITS=4, DATA_BITS=2) with downstream sram_model. Required: grant=01 one cycle after valids, s_awaddr=3, m_bvalid[0]=1, bresp=0, grant returns to 0.
- Single read: master 1 reads addr 0x3 after the write above. Required: m_rdata[3:2]=2'b10, m_rvalid[1] only, m_rvalid[0] stays 0.
- Contention: both masters hold write requests for 4 transactions each. Required: completion order 0,1,0,1,0,1,0,1 and no master waits more than one foreign transaction.
- Same-master priority: master 0 asserts write and read together. Required: write is granted first (s_awvalid before s_arvalid), then the read.
- AW/W skew: s_awready is delayed 3 cycles past s_wready. Required: exactly one W handshake, state waits, and B is returned once.
- Reset mid-read in RD_DATA: required next cycle grant=0, all valids 0. After release, master 0 wins the first tie. With SRAM_AXI_ARBITER_STATS_EN, the counters read 0.
